// File: rtl/alu_control_pipe.sv
// rtl/alu_control_pipe.sv - pipelined table-driven ALU control decoder
// R-type passes funct (JR/JRL -> NOP); other opcodes hit a writable CAM.
module alu_control_pipe #(
  parameter int          OP_W      = 6,
  parameter int          FN_W      = 6,
  parameter int          TBL_DEPTH = 8,
  parameter logic [5:0]  RTYPE_OP  = 6'b000000,
  parameter logic [5:0]  JR_FN     = 6'b010100,
  parameter logic [5:0]  NOP_FN    = 6'b111111,
  parameter int          CNT_W     = 16,
  localparam int         IDX_W     = $clog2(TBL_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  opcode,
  input  logic [FN_W-1:0]  funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FN_W-1:0]  functOut,
  output logic             illegal,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_en,
  input  logic [OP_W-1:0]  cfg_op,
  input  logic [FN_W-1:0]  cfg_fn,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic            tbl_en [TBL_DEPTH];
  logic [OP_W-1:0] tbl_op [TBL_DEPTH];
  logic [FN_W-1:0] tbl_fn [TBL_DEPTH];

  logic            xfer;
  logic            hit;
  logic [FN_W-1:0] hit_fn;
  logic [FN_W-1:0] dec_fn;
  logic            dec_ill;

  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  // Ascending scan with a sticky hit flag gives lowest-index priority.
  always_comb begin
    hit    = 1'b0;
    hit_fn = NOP_FN[FN_W-1:0];
    for (int i = 0; i < TBL_DEPTH; i++) begin
      if (!hit && tbl_en[i] && (tbl_op[i] == opcode)) begin
        hit    = 1'b1;
        hit_fn = tbl_fn[i];
      end
    end
  end

  always_comb begin
    dec_fn  = NOP_FN[FN_W-1:0];
    dec_ill = 1'b0;
    if (opcode == RTYPE_OP[OP_W-1:0]) begin
      if (funct[FN_W-1:1] != JR_FN[FN_W-1:1])
        dec_fn = funct;
    end else if (hit) begin
      dec_fn = hit_fn;
    end else begin
      dec_ill = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      functOut    <= NOP_FN[FN_W-1:0];
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        functOut  <= dec_fn;
        illegal   <= dec_ill;
        if (dec_ill && (illegal_cnt != {CNT_W{1'b1}}))
          illegal_cnt <= illegal_cnt + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL_DEPTH; i++) begin
        tbl_en[i] <= 1'b0;
        tbl_op[i] <= '0;
        tbl_fn[i] <= '0;
      end
      tbl_en[0] <= 1'b1; tbl_op[0] <= OP_W'(1); tbl_fn[0] <= FN_W'(6'b000101);
      tbl_en[1] <= 1'b1; tbl_op[1] <= OP_W'(2); tbl_fn[1] <= FN_W'(6'b000101);
      tbl_en[2] <= 1'b1; tbl_op[2] <= OP_W'(3); tbl_fn[2] <= FN_W'(6'b000101);
      tbl_en[3] <= 1'b1; tbl_op[3] <= OP_W'(4); tbl_fn[3] <= FN_W'(6'b000110);
      tbl_en[4] <= 1'b1; tbl_op[4] <= OP_W'(7); tbl_fn[4] <= FN_W'(6'b010011);
      tbl_en[5] <= 1'b1; tbl_op[5] <= OP_W'(8); tbl_fn[5] <= FN_W'(6'b010100);
    end else if (cfg_we && (int'(cfg_idx) < TBL_DEPTH)) begin
      tbl_en[cfg_idx] <= cfg_en;
      tbl_op[cfg_idx] <= cfg_op;
      tbl_fn[cfg_idx] <= cfg_fn;
    end
  end

endmodule

// File: tb/tb_alu_control_pipe.sv
// tb/tb_alu_control_pipe.sv - scoreboard bench for alu_control_pipe
module tb_alu_control_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [5:0]  functOut;
  logic        illegal;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic        cfg_en = 1'b0;
  logic [5:0]  cfg_op = '0;
  logic [5:0]  cfg_fn = '0;
  logic [15:0] illegal_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int c0;
  logic [6:0] expq [$];

  alu_control_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
    .functOut(functOut), .illegal(illegal), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_en(cfg_en), .cfg_op(cfg_op), .cfg_fn(cfg_fn), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted output is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_output", {25'd0, illegal, functOut}, 32'h7f);
      end else begin
        logic [6:0] e;
        e = expq.pop_front();
        check("functOut", {26'd0, functOut}, {26'd0, e[5:0]});
        check("illegal", {31'd0, illegal}, {31'd0, e[6]});
      end
    end
  end

  task automatic send(input logic [5:0] op, input logic [5:0] fn,
                      input logic [5:0] efn, input logic eill);
    logic ok;
    int   n;
    in_valid = 1'b1;
    opcode   = op;
    funct    = fn;
    expq.push_back({eill, efn});
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 20);
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic cfg_set(input logic [2:0] idx, input logic en,
                         input logic [5:0] op, input logic [5:0] fn);
    cfg_we  = 1'b1;
    cfg_idx = idx;
    cfg_en  = en;
    cfg_op  = op;
    cfg_fn  = fn;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic en,
                           input logic [5:0] op, input logic [5:0] fn);
    cfg_set(idx, en, op, fn);
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_functOut", {26'd0, functOut}, 32'h3f);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_cnt", {16'd0, illegal_cnt}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: back-to-back at full throughput
    c0 = cyc;
    send(6'd1, 6'd0, 6'b000101, 1'b0);
    send(6'd2, 6'd0, 6'b000101, 1'b0);
    send(6'd3, 6'd0, 6'b000101, 1'b0);
    check("throughput_cycles", cyc - c0, 32'd3);
    idle();
    drain();

    // 2: R-type passthrough and JR/JRL
    send(6'd0, 6'b100000, 6'b100000, 1'b0);
    send(6'd0, 6'b010100, 6'b111111, 1'b0);
    send(6'd0, 6'b010101, 6'b111111, 1'b0);
    idle();
    drain();

    // 3: backpressure holds the result
    out_ready = 1'b0;
    send(6'd4, 6'd0, 6'b000110, 1'b0);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_fn", {26'd0, functOut}, {26'd0, 6'b000110});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    c0 = cyc;
    fork
      send(6'd7, 6'd0, 6'b010011, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    check("stall_released_late", {31'd0, (cyc - c0) >= 3}, 32'd1);
    idle();
    drain();

    // 4: unmapped opcode, then map it
    send(6'd9, 6'd0, 6'b111111, 1'b1);
    send(6'd9, 6'd0, 6'b111111, 1'b1);
    idle();
    drain();
    check("cnt_after_2", {16'd0, illegal_cnt}, 32'd2);
    cfg_write(3'd6, 1'b1, 6'd9, 6'b000111);
    send(6'd9, 6'd0, 6'b000111, 1'b0);
    idle();
    drain();
    check("cnt_still_2", {16'd0, illegal_cnt}, 32'd2);

    // 5: same-cycle write uses old contents; duplicate key priority
    cfg_set(3'd0, 1'b1, 6'd1, 6'b000110);
    send(6'd1, 6'd0, 6'b000101, 1'b0);
    cfg_we = 1'b0;
    send(6'd1, 6'd0, 6'b000110, 1'b0);
    idle();
    cfg_write(3'd7, 1'b1, 6'd1, 6'b001001);
    send(6'd1, 6'd0, 6'b000110, 1'b0);
    idle();
    cfg_write(3'd7, 1'b1, 6'd0, 6'b001001);
    send(6'd0, 6'b100010, 6'b100010, 1'b0);
    idle();
    cfg_write(3'd6, 1'b0, 6'd9, 6'b000111);
    send(6'd9, 6'd0, 6'b111111, 1'b1);
    send(6'd9, 6'd0, 6'b111111, 1'b1);
    send(6'd9, 6'd0, 6'b111111, 1'b1);
    idle();
    drain();
    check("cnt_5", {16'd0, illegal_cnt}, 32'd5);

    // 6: asynchronous reset while an output is held
    out_ready = 1'b0;
    send(6'd2, 6'd0, 6'b000101, 1'b0);
    idle();
    @(negedge clk);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_cnt", {16'd0, illegal_cnt}, 32'd0);
    check("async_fn", {26'd0, functOut}, 32'h3f);
    expq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(6'd1, 6'd0, 6'b000101, 1'b0);
    send(6'd9, 6'd0, 6'b111111, 1'b1);
    send(6'd0, 6'b100010, 6'b100010, 1'b0);
    idle();
    drain();
    check("cnt_after_reset", {16'd0, illegal_cnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
